dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-requester arbiter that shares the single data-memory port between the CORE data interface (port 0) and an auxiliary master such as a debug or loader engine (port 1). It sits between CORE and DATA_MEMORY inside DATAPATH. It grants at most one access per cycle, uses round-robin on contention, and supports a bounded lock so port 1 can run back-to-back bursts without starving the core. Read data returns registered, one cycle after grant.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `MAX_LOCK`, 8: maximum consecutive port-1 grants under lock while port 0 is requesting. Legal range 1..255.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset; synchronous and active-high.
- `i_P0_req`, `i_P1_req`  in  1  access request; address, data and write-enable are held stable until grant.
- `i_P0_we`, `i_P1_we`  in  1  1 = write, 0 = read.
- `i_P0_addr`, `i_P1_addr`  in  AW  byte address.
- `i_P0_wd`, `i_P1_wd`  in  DW  write data.
- `i_P1_lock`  in  1  port 1 requests to keep ownership for consecutive accesses.
- `o_P0_gnt`, `o_P1_gnt`  out  1  combinational; the access is performed this cycle.
- `o_P0_rvalid`, `o_P1_rvalid`  out  1  registered; read data is valid this cycle.
- `o_P0_rdata`, `o_P1_rdata`  out  DW  registered read data.
- `o_DM_addr`  out  AW  memory address.
- `o_DM_wd`  out  DW  memory write data.
- `o_DM_wen`  out  1  memory write enable.
- `o_DM_ren`  out  1  memory read enable.
- `i_DM_rd`  in  DW  memory read data. Combinational from `o_DM_addr`/`o_DM_ren` in the same cycle.

## Operation
- **State:**
  - `last`: last winner, 1 bit; reset value 1, so port 0 wins the first contention.
  - `locked`: 1 bit; reset value 0.
  - `lock_cnt`: 8 bits; reset value 0.
- **Winner selection (combinational, per cycle):**
  - Neither port requests: no grant; `o_DM_wen = o_DM_ren = 0`; `o_DM_addr`/`o_DM_wd` are don't-care, driven from port 0.
  - Only one port requests: that port wins.
  - Both request, `locked = 1`, and `lock_cnt < MAX_LOCK`: port 1 wins.
  - Both request otherwise: the port ≠ `last` wins.
- **Memory drive:** mux the winner's addr/wd onto the memory port.
  - `o_DM_wen = win & we`.
  - `o_DM_ren = win & ~we`.
  - Exactly one of `o_Px_gnt` is asserted when any request exists.
- **On every granted cycle:**
  - `last` ← winner.
  - Grant was a read: capture `i_DM_rd` into that port's `o_Px_rdata` and pulse its `o_Px_rvalid` next cycle. The other port's rvalid is 0.
  - `o_Px_rdata` holds its value until the next read for that port.
- **Lock FSM (states UNLOCKED / LOCKED):**
  - UNLOCKED → LOCKED when port 1 is granted with `i_P1_lock = 1`; `lock_cnt` ← 1 if port 0 was requesting, else 0.
  - LOCKED, port 1 granted, `i_P1_lock = 1`: `lock_cnt` increments only while port 0 is requesting. It saturates at `MAX_LOCK`.
  - LOCKED, `lock_cnt = MAX_LOCK`, port 0 requesting: port 0 wins by round-robin (`last = 1`). `lock_cnt` ← 0 and the FSM stays LOCKED, so port 1 resumes next.
  - LOCKED → UNLOCKED when port 1 is granted with `i_P1_lock = 0` (final burst beat), or when `i_P1_req = 0` in any cycle; `lock_cnt` ← 0.
- **Writes:** the memory commits at the grant-cycle edge. No rvalid is generated for a write.

## Timing
- Grant latency is 0 cycles: a request with no contention is granted in the cycle it is raised. Read data latency is 1 cycle after grant.
- A requester must keep `req` and its payload stable until it sees `gnt`. It may drop `req` or present a new request in the cycle after `gnt`.
- Back-to-back grants to the same port are allowed every cycle. Throughput is 1 access per cycle total.
- Worst-case port-0 wait with contention is `MAX_LOCK` cycles. With no lock active it is 1 cycle.
- **Reset:**
  - On any edge with `i_rst = 1`, all state goes to reset values, and `o_Px_rvalid` and `o_Px_rdata` clear to 0 on that same edge.
  - Grants and memory enables are forced to 0 while `i_rst = 1`.
  - An access granted in the same cycle reset is asserted is dropped: no write and no rvalid.
  - A read in flight when reset asserts does not produce rvalid.

## Test plan
- **Single reads/writes:** P0 writes 0xDEADBEEF to 0x10 alone. Next cycle P1 reads 0x10 → `o_P1_gnt = 1` the same cycle, and `o_P1_rvalid = 1` with `o_P1_rdata = 0xDEADBEEF` one cycle later.
- **Contention after reset:** both ports read every cycle for 4 cycles → grants go P0, P1, P0, P1, and each rvalid appears one cycle after its grant.
- **Lock bound:** `MAX_LOCK = 3`, P1 holds lock and req, P0 requests continuously → grant order P1, P1, P1, P0, P1, P1, P1, P0.
- **Lock release:** a P1 burst of 5 with lock deasserted on the 5th beat, P0 idle, then both request → P1 gets 5 consecutive grants, the FSM returns to UNLOCKED, and the next contention is decided by round-robin (P0 wins).
- **Reset mid-operation:** assert `i_rst` in the cycle P1 is granted a write of 0x1234 to 0x20 → memory at 0x20 is unchanged, all outputs are 0 the next cycle, and the first contention after reset goes to P0.
- **Idle behaviour:** no requests for 10 cycles → `o_DM_wen = o_DM_ren = 0` throughout, and both `o_Px_rvalid` remain 0.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// Bundle shared by the two requesters, the data memory and the arbiter.
// The arbiter takes the slave view; whatever drives requests and models the memory takes master.
interface dm_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          i_P0_req;
   logic          i_P1_req;
   logic          i_P0_we;
   logic          i_P1_we;
   logic [AW-1:0] i_P0_addr;
   logic [AW-1:0] i_P1_addr;
   logic [DW-1:0] i_P0_wd;
   logic [DW-1:0] i_P1_wd;
   logic          i_P1_lock;
   logic          o_P0_gnt;
   logic          o_P1_gnt;
   logic          o_P0_rvalid;
   logic          o_P1_rvalid;
   logic [DW-1:0] o_P0_rdata;
   logic [DW-1:0] o_P1_rdata;
   logic [AW-1:0] o_DM_addr;
   logic [DW-1:0] o_DM_wd;
   logic          o_DM_wen;
   logic          o_DM_ren;
   logic [DW-1:0] i_DM_rd;

   modport slave (
      input  i_P0_req, i_P1_req, i_P0_we, i_P1_we, i_P0_addr, i_P1_addr,
             i_P0_wd, i_P1_wd, i_P1_lock, i_DM_rd,
      output o_P0_gnt, o_P1_gnt, o_P0_rvalid, o_P1_rvalid, o_P0_rdata,
             o_P1_rdata, o_DM_addr, o_DM_wd, o_DM_wen, o_DM_ren
   );

   modport master (
      output i_P0_req, i_P1_req, i_P0_we, i_P1_we, i_P0_addr, i_P1_addr,
             i_P0_wd, i_P1_wd, i_P1_lock, i_DM_rd,
      input  o_P0_gnt, o_P1_gnt, o_P0_rvalid, o_P1_rvalid, o_P0_rdata,
             o_P1_rdata, o_DM_addr, o_DM_wd, o_DM_wen, o_DM_ren
   );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter for the data-memory port, with a bounded lock that
// lets port 1 burst while still guaranteeing port 0 a slot every MAX_LOCK grants.
module dm_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_LOCK = 8
) (
   input logic          i_clk,
   input logic          i_rst,
   dm_arbiter_if.slave  bus
);
   localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

   typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

   lock_state_t   state_reg;
   logic          last_reg;
   logic [7:0]    lock_cnt_reg;

   logic [1:0]    req;
   logic [1:0]    we;
   logic [1:0]    gnt;
   logic [AW-1:0] addr [2];
   logic [DW-1:0] wd   [2];
   logic          lock_win;
   logic          win1;

   assign req     = {bus.i_P1_req, bus.i_P0_req};
   assign we      = {bus.i_P1_we, bus.i_P0_we};
   assign addr[0] = bus.i_P0_addr;
   assign addr[1] = bus.i_P1_addr;
   assign wd[0]   = bus.i_P0_wd;
   assign wd[1]   = bus.i_P1_wd;

   // last_reg holds the previous winner, so on contention port 1 wins when port 0 went last.
   assign lock_win = (state_reg == LOCKED) && (lock_cnt_reg < MAX_CNT);
   assign win1     = req[1] & (~req[0] | lock_win | ~last_reg);
   assign gnt[1]   = ~i_rst & win1;
   assign gnt[0]   = ~i_rst & req[0] & ~win1;

   assign bus.o_P0_gnt  = gnt[0];
   assign bus.o_P1_gnt  = gnt[1];
   assign bus.o_DM_addr = win1 ? addr[1] : addr[0];
   assign bus.o_DM_wd   = win1 ? wd[1] : wd[0];
   assign bus.o_DM_wen  = |(gnt & we);
   assign bus.o_DM_ren  = |(gnt & ~we);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ret
         logic          rvalid_reg;
         logic [DW-1:0] rdata_reg;

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               rvalid_reg <= 1'b0;
               rdata_reg  <= '0;
            end else begin
               rvalid_reg <= gnt[gi] & ~we[gi];
               if (gnt[gi] & ~we[gi]) begin
                  rdata_reg <= bus.i_DM_rd;
               end
            end
         end
      end
   endgenerate

   assign bus.o_P0_rvalid = g_ret[0].rvalid_reg;
   assign bus.o_P1_rvalid = g_ret[1].rvalid_reg;
   assign bus.o_P0_rdata  = g_ret[0].rdata_reg;
   assign bus.o_P1_rdata  = g_ret[1].rdata_reg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg    <= UNLOCKED;
         last_reg     <= 1'b1;
         lock_cnt_reg <= '0;
      end else begin
         if (|gnt) begin
            last_reg <= gnt[1];
         end
         if (!req[1]) begin
            state_reg    <= UNLOCKED;
            lock_cnt_reg <= '0;
         end else if (gnt[1]) begin
            if (!bus.i_P1_lock) begin
               state_reg    <= UNLOCKED;
               lock_cnt_reg <= '0;
            end else if (state_reg == UNLOCKED) begin
               state_reg    <= LOCKED;
               lock_cnt_reg <= {7'b0, req[0]};
            end else if (req[0] && (lock_cnt_reg < MAX_CNT)) begin
               lock_cnt_reg <= lock_cnt_reg + 8'd1;
            end
         end else if (gnt[0] && (state_reg == LOCKED)) begin
            // Port 0 took its guaranteed slot; port 1 keeps the lock and resumes next.
            lock_cnt_reg <= '0;
         end
      end
   end
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed vector bench for dm_arbiter with MAX_LOCK = 3 and a small word-addressed memory model.
module tb_dm_arbiter;
   localparam logic [31:0] DB = 32'hDEADBEEF;
   localparam logic [31:0] M5 = 32'hA000_0005;
   localparam int          NV = 32;

   typedef struct {
      logic [5:0]  ctl;   // {rst, p0_req, p0_we, p1_req, p1_we, p1_lock}
      logic [31:0] a0;
      logic [31:0] d0;
      logic [31:0] a1;
      logic [31:0] d1;
      logic [5:0]  exp;   // {gnt0, gnt1, wen, ren, rvalid0, rvalid1}
      logic [31:0] rd0;
      logic [31:0] rd1;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        mem_init;
   logic [31:0] mem [256];
   vec_t        tbl [NV];
   int          n_checks;
   int          n_fail;

   dm_arbiter_if #(.AW(32), .DW(32)) bus ();

   dm_arbiter #(.AW(32), .DW(32), .MAX_LOCK(3)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.i_DM_rd = mem[bus.o_DM_addr[9:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      end else if (bus.o_DM_wen) begin
         mem[bus.o_DM_addr[9:2]] <= bus.o_DM_wd;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic drive(input vec_t v);
      rst           = v.ctl[5];
      bus.i_P0_req  = v.ctl[4];
      bus.i_P0_we   = v.ctl[3];
      bus.i_P1_req  = v.ctl[2];
      bus.i_P1_we   = v.ctl[1];
      bus.i_P1_lock = v.ctl[0];
      bus.i_P0_addr = v.a0;
      bus.i_P0_wd   = v.d0;
      bus.i_P1_addr = v.a1;
      bus.i_P1_wd   = v.d1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      tbl[0]  = '{6'b0_11_00_0, 32'h10, DB, 32'h0, 32'h0, 6'b10_10_00, 32'h0, 32'h0};
      tbl[1]  = '{6'b0_00_10_0, 32'h0, 32'h0, 32'h10, 32'h0, 6'b01_01_00, 32'h0, 32'h0};
      tbl[2]  = '{6'b0_00_00_0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b00_00_01, 32'h0, DB};
      tbl[3]  = '{6'b1_00_00_0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b00_00_00, 32'h0, DB};
      tbl[4]  = '{6'b0_10_10_0, 32'h10, 32'h0, 32'h14, 32'h0, 6'b10_01_00, 32'h0, 32'h0};
      tbl[5]  = '{6'b0_10_10_0, 32'h10, 32'h0, 32'h14, 32'h0, 6'b01_01_10, DB, 32'h0};
      tbl[6]  = '{6'b0_10_10_0, 32'h10, 32'h0, 32'h14, 32'h0, 6'b10_01_01, DB, M5};
      tbl[7]  = '{6'b0_10_10_0, 32'h10, 32'h0, 32'h14, 32'h0, 6'b01_01_10, DB, M5};
      tbl[8]  = '{6'b0_00_00_0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b00_00_01, DB, M5};
      tbl[9]  = '{6'b0_10_00_0, 32'h10, 32'h0, 32'h0, 32'h0, 6'b10_01_00, DB, M5};
      // Locked burst against a continuously requesting port 0.
      tbl[10] = '{6'b0_10_10_1, 32'h10, 32'h0, 32'h14, 32'h0, 6'b01_01_10, DB, M5};
      tbl[11] = '{6'b0_10_10_1, 32'h10, 32'h0, 32'h14, 32'h0, 6'b01_01_01, DB, M5};
      tbl[12] = '{6'b0_10_10_1, 32'h10, 32'h0, 32'h14, 32'h0, 6'b01_01_01, DB, M5};
      tbl[13] = '{6'b0_10_10_1, 32'h10, 32'h0, 32'h14, 32'h0, 6'b10_01_01, DB, M5};
      tbl[14] = '{6'b0_10_10_1, 32'h10, 32'h0, 32'h14, 32'h0, 6'b01_01_10, DB, M5};
      tbl[15] = '{6'b0_10_10_1, 32'h10, 32'h0, 32'h14, 32'h0, 6'b01_01_01, DB, M5};
      tbl[16] = '{6'b0_10_10_1, 32'h10, 32'h0, 32'h14, 32'h0, 6'b01_01_01, DB, M5};
      tbl[17] = '{6'b0_10_10_1, 32'h10, 32'h0, 32'h14, 32'h0, 6'b10_01_01, DB, M5};
      tbl[18] = '{6'b0_00_00_0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b00_00_10, DB, M5};
      for (int k = 0; k < 5; k++) begin
         tbl[19+k] = '{{5'b0_00_11, (k < 4) ? 1'b1 : 1'b0}, 32'h0, 32'h0,
                       32'h40 + 32'(4*k), 32'h5000 + 32'(k), 6'b01_10_00, DB, M5};
      end
      tbl[24] = '{6'b0_10_10_0, 32'h10, 32'h0, 32'h40, 32'h0, 6'b10_01_00, DB, M5};
      tbl[25] = '{6'b0_10_10_0, 32'h10, 32'h0, 32'h40, 32'h0, 6'b01_01_10, DB, M5};
      tbl[26] = '{6'b0_00_00_0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b00_00_01, DB, 32'h5000};
      tbl[27] = '{6'b1_00_11_0, 32'h0, 32'h0, 32'h20, 32'h1234, 6'b00_00_00, DB, 32'h5000};
      tbl[28] = '{6'b0_00_00_0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b00_00_00, 32'h0, 32'h0};
      tbl[29] = '{6'b0_10_10_0, 32'h10, 32'h0, 32'h20, 32'h0, 6'b10_01_00, 32'h0, 32'h0};
      tbl[30] = '{6'b0_10_10_0, 32'h10, 32'h0, 32'h20, 32'h0, 6'b01_01_10, DB, 32'h0};
      tbl[31] = '{6'b0_00_00_0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b00_00_01, DB, 32'hA000_0008};

      mem_init = 1'b1;
      drive('{6'b1_00_00_0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b0, 32'h0, 32'h0});
      repeat (2) @(posedge clk);
      #1;
      mem_init = 1'b0;
      // Grant must stay suppressed while reset is held, even with a request present.
      bus.i_P0_req  = 1'b1;
      bus.i_P0_addr = 32'h10;
      @(negedge clk);
      check("rst gnt0", {31'b0, bus.o_P0_gnt}, 32'h0);
      check("rst ren", {31'b0, bus.o_DM_ren}, 32'h0);
      check("rst rvalid0", {31'b0, bus.o_P0_rvalid}, 32'h0);
      check("rst rvalid1", {31'b0, bus.o_P1_rvalid}, 32'h0);
      check("rst rdata0", bus.o_P0_rdata, 32'h0);
      check("rst rdata1", bus.o_P1_rdata, 32'h0);
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         $display("vec %0d: ctl=%b gnt=%b%b wen=%b ren=%b rv=%b%b rd0=%h rd1=%h",
                  i, tbl[i].ctl, bus.o_P0_gnt, bus.o_P1_gnt, bus.o_DM_wen, bus.o_DM_ren,
                  bus.o_P0_rvalid, bus.o_P1_rvalid, bus.o_P0_rdata, bus.o_P1_rdata);
         check($sformatf("v%0d gnt0", i), {31'b0, bus.o_P0_gnt}, {31'b0, tbl[i].exp[5]});
         check($sformatf("v%0d gnt1", i), {31'b0, bus.o_P1_gnt}, {31'b0, tbl[i].exp[4]});
         check($sformatf("v%0d wen", i), {31'b0, bus.o_DM_wen}, {31'b0, tbl[i].exp[3]});
         check($sformatf("v%0d ren", i), {31'b0, bus.o_DM_ren}, {31'b0, tbl[i].exp[2]});
         check($sformatf("v%0d rvalid0", i), {31'b0, bus.o_P0_rvalid}, {31'b0, tbl[i].exp[1]});
         check($sformatf("v%0d rvalid1", i), {31'b0, bus.o_P1_rvalid}, {31'b0, tbl[i].exp[0]});
         check($sformatf("v%0d rdata0", i), bus.o_P0_rdata, tbl[i].rd0);
         check($sformatf("v%0d rdata1", i), bus.o_P1_rdata, tbl[i].rd1);
         @(posedge clk);
         #1;
      end

      check("mem 0x20 kept", mem[8], 32'hA000_0008);
      check("mem 0x10 written", mem[4], DB);

      drive('{6'b0_00_00_0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b0, 32'h0, 32'h0});
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         $display("idle %0d: wen=%b ren=%b rv=%b%b", c, bus.o_DM_wen, bus.o_DM_ren,
                  bus.o_P0_rvalid, bus.o_P1_rvalid);
         check($sformatf("idle%0d wen", c), {31'b0, bus.o_DM_wen}, 32'h0);
         check($sformatf("idle%0d ren", c), {31'b0, bus.o_DM_ren}, 32'h0);
         check($sformatf("idle%0d rvalid0", c), {31'b0, bus.o_P0_rvalid}, 32'h0);
         check($sformatf("idle%0d rvalid1", c), {31'b0, bus.o_P1_rvalid}, 32'h0);
         @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
